// File: rtl/dist_ram_fifo_pkg.sv
// Shared helpers for the distributed-RAM FWFT FIFO.
// Pointer sizing, count type and almost-full threshold validation.
package dist_ram_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  // Occupancy of the default configuration, 0..depth.
  typedef logic [DEF_ADDR_WIDTH:0] count_t;

  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

  // A depth-1 FIFO still needs a one-bit storage index.
  function automatic int idx_width(input int aw);
    return (aw > 0) ? aw : 1;
  endfunction

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  function automatic bit thr_valid(input int thr, input int aw);
    return (thr > 0) && (thr <= depth_of(aw));
  endfunction

endpackage

// File: rtl/dist_ram_fifo_ptr_ctrl.sv
// Read/write pointers, occupancy and status flags for dist_ram_fifo.
// Almost-full flag only with DIST_RAM_FIFO_ALMOST_FULL_EN.
module fifo_ptr_ctrl
  import dist_ram_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
`ifdef DIST_RAM_FIFO_ALMOST_FULL_EN
  ,parameter int ALMOST_FULL_THRESHOLD = (2**ADDR_WIDTH) - 2
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push_req,
  input  logic pop_req,
  output logic wr_en,
  output logic [idx_width(ADDR_WIDTH)-1:0] wr_idx,
  output logic [idx_width(ADDR_WIDTH)-1:0] rd_idx,
  output logic [ADDR_WIDTH:0] count,
  output logic full,
  output logic empty
`ifdef DIST_RAM_FIFO_ALMOST_FULL_EN
  ,output logic almost_full
`endif
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam int IW = idx_width(ADDR_WIDTH);
  localparam logic [PW-1:0] DEPTH_C = PW'(depth_of(ADDR_WIDTH));

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_nxt;
  logic [PW-1:0] rd_nxt;
  logic push;
  logic pop;
  op_e op;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == DEPTH_C);
  assign empty = (wr_ptr == rd_ptr);

  assign push  = push_req && !full;
  assign pop   = pop_req && !empty;
  assign wr_en = push && !flush;

  assign wr_idx = (ADDR_WIDTH > 0) ? wr_ptr[IW-1:0] : '0;
  assign rd_idx = (ADDR_WIDTH > 0) ? rd_ptr[IW-1:0] : '0;

  always_comb begin
    op     = op_e'({push, pop});
    wr_nxt = wr_ptr;
    rd_nxt = rd_ptr;
    if (flush) begin
      wr_nxt = '0;
      rd_nxt = '0;
    end else begin
      unique case (op)
        OP_IDLE: ;
        OP_POP:  rd_nxt = rd_ptr + 1'b1;
        OP_PUSH: wr_nxt = wr_ptr + 1'b1;
        OP_BOTH: begin
          wr_nxt = wr_ptr + 1'b1;
          rd_nxt = rd_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
    end
  end

`ifdef DIST_RAM_FIFO_ALMOST_FULL_EN
  if (!thr_valid(ALMOST_FULL_THRESHOLD, ADDR_WIDTH)) begin : g_bad_thr
    $error("ALMOST_FULL_THRESHOLD must be in 1..2**ADDR_WIDTH");
  end

  assign almost_full = (int'(count) >= ALMOST_FULL_THRESHOLD);
`endif

endmodule

// File: rtl/dist_ram_fifo.sv
// First-word-fall-through FIFO on distributed RAM with valid/ready ports.
// Define DIST_RAM_FIFO_ALMOST_FULL_EN to add o_almost_full.
module dist_ram_fifo
  import dist_ram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
`ifdef DIST_RAM_FIFO_ALMOST_FULL_EN
  ,parameter int ALMOST_FULL_THRESHOLD = (2**ADDR_WIDTH) - 2
`endif
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_flush,
  input  logic i_wr_valid,
  output logic o_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic o_rd_valid,
  input  logic i_rd_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [ADDR_WIDTH:0] o_count,
  output logic o_full,
  output logic o_empty
`ifdef DIST_RAM_FIFO_ALMOST_FULL_EN
  ,output logic o_almost_full
`endif
);

  localparam int IW    = idx_width(ADDR_WIDTH);
  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic wr_en;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  // Contents are never reset; they only start known at power-up.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  fifo_ptr_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH)
`ifdef DIST_RAM_FIFO_ALMOST_FULL_EN
    ,.ALMOST_FULL_THRESHOLD(ALMOST_FULL_THRESHOLD)
`endif
  ) u_ptr (
    .clk(i_clk),
    .rst_n(i_rst_n),
    .flush(i_flush),
    .push_req(i_wr_valid),
    .pop_req(i_rd_ready),
    .wr_en(wr_en),
    .wr_idx(wr_idx),
    .rd_idx(rd_idx),
    .count(o_count),
    .full(o_full),
    .empty(o_empty)
`ifdef DIST_RAM_FIFO_ALMOST_FULL_EN
    ,.almost_full(o_almost_full)
`endif
  );

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data  = mem[rd_idx];
  assign o_wr_ready = !o_full;
  assign o_rd_valid = !o_empty;

endmodule

// File: tb/tb_dist_ram_fifo.sv
// Self-checking bench for dist_ram_fifo: vector table plus queue scoreboard.
// Almost-full checks run when DIST_RAM_FIFO_ALMOST_FULL_EN is defined.
module tb_dist_ram_fifo;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic rd_valid;
  logic rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic [AW:0] count;
  logic full;
  logic empty;
`ifdef DIST_RAM_FIFO_ALMOST_FULL_EN
  logic almost_full;
`endif

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb[$];

  typedef struct {
    logic wv;
    logic [DW-1:0] wd;
    logic rr;
    logic fl;
    int exp_count;
    logic exp_valid;
    logic [DW-1:0] exp_head;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  dist_ram_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_flush(flush),
    .i_wr_valid(wr_valid),
    .o_wr_ready(wr_ready),
    .i_wr_data(wr_data),
    .o_rd_valid(rd_valid),
    .i_rd_ready(rd_ready),
    .o_rd_data(rd_data),
    .o_count(count),
    .o_full(full),
    .o_empty(empty)
`ifdef DIST_RAM_FIFO_ALMOST_FULL_EN
    ,.o_almost_full(almost_full)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int n;
    n = sb.size();
    chk("count", 64'(count), 64'(n));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("full", 64'(full), 64'(n == DEPTH));
    chk("rd_valid", 64'(rd_valid), 64'(n != 0));
    chk("wr_ready", 64'(wr_ready), 64'(n != DEPTH));
  endtask

  // Drive one cycle; check state at negedge, update model, end after edge.
  task automatic cycle(input logic wv, input logic [DW-1:0] wd,
                       input logic rr, input logic fl);
    logic push_ok;
    logic pop_ok;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    @(negedge clk);
    check_state();
    push_ok = wv && (sb.size() < DEPTH);
    pop_ok  = rr && (sb.size() > 0);
    if (fl) begin
      sb.delete();
    end else begin
      if (pop_ok) chk("pop_data", 64'(rd_data), 64'(sb.pop_front()));
      if (push_ok) sb.push_back(wd);
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h11, 1'b0, 1'b0, 1, 1'b1, 32'h11};
    vecs[1] = '{1'b1, 32'h22, 1'b0, 1'b0, 2, 1'b1, 32'h11};
    vecs[2] = '{1'b1, 32'h33, 1'b1, 1'b0, 2, 1'b1, 32'h22};
    vecs[3] = '{1'b0, 32'h00, 1'b1, 1'b0, 1, 1'b1, 32'h33};
    vecs[4] = '{1'b1, 32'h44, 1'b0, 1'b1, 0, 1'b0, 32'h00};
    vecs[5] = '{1'b1, 32'h55, 1'b0, 1'b0, 1, 1'b1, 32'h55};
    vecs[6] = '{1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b0, 32'h00};
    vecs[7] = '{1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b0, 32'h00};
    vecs[8] = '{1'b1, 32'h66, 1'b1, 1'b0, 1, 1'b1, 32'h66};
    vecs[9] = '{1'b1, 32'h77, 1'b1, 1'b0, 1, 1'b1, 32'h77};

    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset then idle
    @(negedge clk);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    @(posedge clk);
    #1;

    // Vector table
    foreach (vecs[i]) begin
      cycle(vecs[i].wv, vecs[i].wd, vecs[i].rr, vecs[i].fl);
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
      chk($sformatf("vec%0d_valid", i), 64'(rd_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_head", i), 64'(rd_data), 64'(vecs[i].exp_head));
    end
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Fill to full, refuse 17th, drain in order
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    chk("full_flag", 64'(full), 64'd1);
    chk("full_wr_ready", 64'(wr_ready), 64'd0);
    chk("full_count", 64'(count), 64'd16);
    cycle(1'b1, 32'h99, 1'b0, 1'b0);
    chk("overflow_count", 64'(count), 64'd16);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("full_to_ready", 64'(wr_ready), 64'd1);
    for (int i = 1; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("drain_empty", 64'(empty), 64'd1);

    // Half full, push and pop together across pointer wrap
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h100 + DW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 32'h200 + DW'(i), 1'b1, 1'b0);
    chk("steady_count", 64'(count), 64'd8);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Push while empty is visible only next cycle
    wr_valid = 1'b1;
    wr_data  = 32'hA5;
    @(negedge clk);
    chk("a5_same_cycle_valid", 64'(rd_valid), 64'd0);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    sb.push_back(32'hA5);
    chk("a5_next_valid", 64'(rd_valid), 64'd1);
    chk("a5_next_data", 64'(rd_data), 64'hA5);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush beats a simultaneous push and pop
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h300 + DW'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'hDEAD, 1'b1, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    cycle(1'b1, 32'h400, 1'b0, 1'b0);
    cycle(1'b1, 32'h401, 1'b0, 1'b0);
    chk("post_flush_head", 64'(rd_data), 64'h400);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

`ifdef DIST_RAM_FIFO_ALMOST_FULL_EN
    for (int i = 0; i < 13; i++) cycle(1'b1, 32'h500 + DW'(i), 1'b0, 1'b0);
    chk("af_at_13", 64'(almost_full), 64'd0);
    cycle(1'b1, 32'h50D, 1'b0, 1'b0);
    chk("af_at_14", 64'(almost_full), 64'd1);
    for (int i = 0; i < 14; i++) cycle(1'b0, '0, 1'b1, 1'b0);
`endif

    // Async reset mid-operation with 10 entries
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'h600 + DW'(i), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_full", 64'(full), 64'd0);
    chk("arst_rd_valid", 64'(rd_valid), 64'd0);
    chk("arst_wr_ready", 64'(wr_ready), 64'd1);
`ifdef DIST_RAM_FIFO_ALMOST_FULL_EN
    chk("arst_af", 64'(almost_full), 64'd0);
`endif
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom % 2), DW'($urandom), 1'($urandom % 2),
            1'($urandom_range(0, 40) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
